// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: left-edge transmitter for the systolic PE array.
// Accepts one ROWS-wide activation vector per handshake. Row r of each vector
// reaches the array r cycles after row 0. Every driven element carries a valid
// tag, and done pulses once the tile's last element is on the bottom row.
// Optional build macro SKEW_FEEDER_BUBBLE_CNT_EN adds a saturating bubble_cnt
// output. It counts FEED cycles in which no vector was offered.
//
// state | meaning
// IDLE  | no tile in progress; ready for the first vector of a tile
// FEED  | tile in progress; vectors or bubbles enter the skew pipeline
// FLUSH | last vector taken; waiting for it to reach the bottom row
module systolic_skew_feeder #(
    parameter int ROWS = 4,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*DW-1:0]   in_data,
    input  logic                 in_last,
    output logic [ROWS*DW-1:0]   d_out,
    output logic [ROWS-1:0]      d_valid,
    output logic                 busy,
    output logic                 done
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]          bubble_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;

    state_t stateQ, stateD;
    logic   accept;
    logic   lastSr [0:ROWS-1];

    assign accept = in_valid & in_ready;

    // Per-row skew: r delay stages plus the output register. A non-accept
    // cycle loads a zero bubble, so data is zero wherever valid is low.
    for (genvar r = 0; r < ROWS; r++) begin : gRow
        logic [DW-1:0] dataSr  [0:r];
        logic          validSr [0:r];

        // Shift this row's element and its valid tag one stage per cycle
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= r; k++) begin
                    dataSr[k]  <= '0;
                    validSr[k] <= 1'b0;
                end
            end else begin
                dataSr[0]  <= accept ? in_data[r*DW +: DW] : '0;
                validSr[0] <= accept;
                for (int k = 1; k <= r; k++) begin
                    dataSr[k]  <= dataSr[k-1];
                    validSr[k] <= validSr[k-1];
                end
            end
        end

        assign d_out[r*DW +: DW] = dataSr[r];
        assign d_valid[r]        = validSr[r];
    end

    // The last tag follows the bottom row's element down its delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ROWS; k++) begin
                lastSr[k] <= 1'b0;
            end
        end else begin
            lastSr[0] <= accept & in_last;
            for (int k = 1; k < ROWS; k++) begin
                lastSr[k] <= lastSr[k-1];
            end
        end
    end

    assign done = lastSr[ROWS-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state and handshake/status outputs
    always_comb begin
        stateD   = stateQ;
        in_ready = 1'b1;
        busy     = 1'b1;
        case (stateQ)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    stateD = in_last ? FLUSH : FEED;
                end
            end
            FEED: begin
                if (accept && in_last) begin
                    stateD = FLUSH;
                end
            end
            FLUSH: begin
                in_ready = 1'b0;
                if (done) begin
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    // Count starved FEED cycles. Restart at each tile start and saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (stateQ == IDLE && accept) begin
            bubble_cnt <= '0;
        end else if (stateQ == FEED && !in_valid && bubble_cnt != 16'hFFFF) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder (ROWS=4, DW=8).
// Stimulus pushes the expected (cycle, row, data) elements for each vector
// the bench expects to be accepted. A negedge monitor pops and compares them,
// and it also checks done and in_ready against the bench's tile model.
module tb_systolic_skew_feeder;

    localparam int ROWS = 4;
    localparam int DW   = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic                 in_last;
    logic [ROWS*DW-1:0]   d_out;
    logic [ROWS-1:0]      d_valid;
    logic                 busy;
    logic                 done;
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    logic [15:0]          bubble_cnt;
`endif

    systolic_skew_feeder #(.ROWS(ROWS), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .d_out    (d_out),
        .d_valid  (d_valid),
        .busy     (busy),
        .done     (done)
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    typedef struct {
        int           cyc;
        int           row;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   flushFrom = 0;
    int   doneCyc = -1;
    int   nCmp = 0;
    int   nBad = 0;
    bit   running = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit modelReady(input int c);
        return !(c >= flushFrom && c <= doneCyc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every row, done and in_ready once per cycle
    always @(negedge clk) begin
        if (running) begin
            for (int r = 0; r < ROWS; r++) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].row == r && sb[i].cyc == cyc) idx = i;
                end
                if (idx >= 0) begin
                    chk($sformatf("row%0d_valid", r), 32'(d_valid[r]), 32'd1);
                    chk($sformatf("row%0d_data", r), 32'(d_out[r*DW +: DW]), 32'(sb[idx].data));
                    sb.delete(idx);
                end else begin
                    chk($sformatf("row%0d_bubble_valid", r), 32'(d_valid[r]), 32'd0);
                    chk($sformatf("row%0d_bubble_data", r), 32'(d_out[r*DW +: DW]), 32'd0);
                end
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc < cyc) begin
                    chk($sformatf("row%0d_missing", sb[i].row), 32'd0, 32'(sb[i].data));
                    sb.delete(i);
                end
            end
            chk("done", 32'(done), 32'(cyc == doneCyc));
            chk("in_ready", 32'(in_ready), 32'(modelReady(cyc)));
        end
    end

    // One cycle of stimulus; returns whether the model expects an accept
    task automatic step(input logic v, input logic [31:0] d, input logic l, output bit acc);
        int c;
        c = cyc;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        acc = v && !rst && modelReady(c);
        if (acc) begin
            for (int r = 0; r < ROWS; r++) begin
                exp_t e;
                e.cyc  = c + 1 + r;
                e.row  = r;
                e.data = d[r*DW +: DW];
                sb.push_back(e);
            end
            if (l) begin
                flushFrom = c + 1;
                doneCyc   = c + ROWS;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, a);
    endtask

    initial begin
        bit a;
        int c0;
        int lastC;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        running = 1;
        @(posedge clk); #1;
        chk("reset_dout", d_out, 32'h0);
        chk("reset_dvalid", 32'(d_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Three contiguous vectors, last on the third
        c0 = cyc;
        step(1'b1, 32'h04030201, 1'b0, a);
        step(1'b1, 32'h08070605, 1'b0, a);
        step(1'b1, 32'h0C0B0A09, 1'b1, a);
        chk("s1_busy_flush", 32'(busy), 32'd1);
        chk("s1_done_cycle", 32'(doneCyc), 32'(c0 + 6));
        idle(6);
        chk("s1_busy_idle", 32'(busy), 32'd0);

        // Vector, bubble, last vector
        step(1'b1, 32'hA4A3A2A1, 1'b0, a);
        idle(1);
        lastC = cyc;
        step(1'b1, 32'hB4B3B2B1, 1'b1, a);
        chk("s2_done_cycle", 32'(doneCyc), 32'(lastC + 4));
        idle(6);

        // Single-vector tile, in_valid held high through FLUSH
        step(1'b1, 32'h11223344, 1'b1, a);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hDEADBEEF, 1'b0, a);
            chk("s3_flush_reject", 32'(a), 32'd0);
        end
        idle(3);

        // Reset two cycles into FLUSH
        step(1'b1, 32'h55555555, 1'b0, a);
        step(1'b1, 32'h66666666, 1'b1, a);
        idle(2);
        rst = 1'b1;
        sb.delete();
        flushFrom = 0;
        doneCyc = -1;
        #1;
        chk("rst_async_dout", d_out, 32'h0);
        chk("rst_async_dvalid", 32'(d_valid), 32'h0);
        chk("rst_async_done", 32'(done), 32'd0);
        chk("rst_async_ready", 32'(in_ready), 32'd1);
        idle(2);
        rst = 1'b0;
        c0 = cyc;
        step(1'b1, 32'h04030201, 1'b0, a);
        step(1'b1, 32'h08070605, 1'b0, a);
        step(1'b1, 32'h0C0B0A09, 1'b1, a);
        chk("s4_done_cycle", 32'(doneCyc), 32'(c0 + 6));
        idle(6);

        // Back-to-back tiles with the next first vector offered continuously
        step(1'b1, 32'h71727374, 1'b0, a);
        lastC = cyc;
        step(1'b1, 32'h81828384, 1'b1, a);
        a = 0;
        for (int i = 0; i < 20 && !a; i++) begin
            c0 = cyc;
            step(1'b1, 32'h91929394, 1'b0, a);
        end
        chk("b2b_accepted", 32'(a), 32'd1);
        chk("b2b_accept_cyc", 32'(c0), 32'(lastC + 5));
        step(1'b1, 32'hA1A2A3A4, 1'b1, a);
        idle(6);

`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
        step(1'b1, 32'h01010101, 1'b0, a);
        idle(5);
        step(1'b1, 32'h02020202, 1'b1, a);
        idle(6);
        chk("bubble_cnt_five", 32'(bubble_cnt), 32'd5);
        idle(2);
        chk("bubble_cnt_hold", 32'(bubble_cnt), 32'd5);
        step(1'b1, 32'h03030303, 1'b1, a);
        chk("bubble_cnt_clear", 32'(bubble_cnt), 32'd0);
        idle(6);
`endif

        idle(2);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        running = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Left-edge data transmitter for the systolic PE array: accepts one ROWS-wide activation vector per handshake and drives the array's per-row data inputs.
- Skews the vector so row r receives its element r cycles after row 0, matching the one-register-per-hop timing of the PE chain.
- Tags each driven element with a valid bit so the output drain can discard bubble sums.
- Signals end of tile once the last element has entered the bottom row.

Parameters:
- ROWS, 4, number of array rows fed (>=1)
- DW, 8, data width per row element

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  vector offered
- in_ready  output  1  feeder can accept vector
- in_data  input  ROWS*DW  activation vector; row r = bits [r*DW +: DW]
- in_last  input  1  marks final vector of tile, qualified by in_valid&in_ready
- d_out  output  ROWS*DW  skewed data to array row inputs; row r = [r*DW +: DW]
- d_valid  output  ROWS  per-row element valid
- busy  output  1  high in FEED or FLUSH
- done  output  1  one-cycle pulse: last element presented on row ROWS-1

Behaviour:
- Accept = in_valid & in_ready, sampled at posedge clk.
- Reset (async, any time, including mid-tile):
  - d_out=0, d_valid=0, done=0, state=IDLE, all skew stages and tags cleared, in_ready=1.
  - In-flight data is discarded; no done pulse.
- Skew pipeline:
  - Row r has an r-stage delay line followed by one output register.
  - A vector accepted at edge t drives row r on d_out from edge t+1+r for exactly one cycle, with d_valid[r]=1.
  - Row 0 latency = 1 cycle; row ROWS-1 latency = ROWS cycles.
- Non-accept cycles: a bubble (data 0, valid 0, last 0) enters the pipeline. Bubbles skew identically to data, so d_out is 0 wherever d_valid=0.
- Last tag: travels with row ROWS-1's element. done=1 exactly when row ROWS-1 presents the tagged element (d_valid[ROWS-1]=1), ROWS cycles after the in_last accept.
- State machine:
  - IDLE: in_ready=1, busy=0. Accept with in_last=0 -> FEED; accept with in_last=1 -> FLUSH.
  - FEED: in_ready=1, busy=1. Accept with in_last=1 -> FLUSH; otherwise stay (bubbles allowed).
  - FLUSH: in_ready=0, busy=1. Leave for IDLE at the edge following the done cycle; in_ready returns to 1 on the first IDLE cycle.
- Back-to-back tiles: the next tile's first vector can be accepted the cycle after done. No overlap between tiles.
- ROWS=1: done asserts 1 cycle after the in_last accept.
- Data passes through unmodified; no arithmetic, no width change.

Optional Feature:
- Macro: SKEW_FEEDER_BUBBLE_CNT_EN.
- Defined:
  - Extra output port bubble_cnt [15:0] counts FEED cycles with in_valid=0 (starved cycles).
  - Saturates at 16'hFFFF.
  - Cleared by rst and on the IDLE->FEED/FLUSH transition.
  - Holds its value in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ROWS=4, reset then 3 contiguous vectors {04030201},{08070605},{0C0B0A09} with in_last on the third:
  - Row 0 shows 01,05,09 at cycles t+1..t+3.
  - Row 3 shows 04,08,0C at t+4..t+6.
  - done at t+6 only; in_ready=0 from t+3 through t+6, 1 at t+7.
- Bubble: vector A, one idle cycle, vector B (last) -> each row shows A, 0 with d_valid=0, B at its skewed offset; done 4 cycles after the B accept.
- Single-vector tile (in_valid & in_last in IDLE) -> direct IDLE->FLUSH; done 4 cycles later; in_valid held high during FLUSH is not accepted.
- Assert rst mid-FLUSH (2 cycles after in_last) -> outputs zero immediately (async); no done pulse; in_ready=1; next tile behaves as in the first scenario.
- Two back-to-back tiles, second first vector offered continuously -> accepted on the cycle after done; no element of tile 2 appears before tile 1's done.
- With SKEW_FEEDER_BUBBLE_CNT_EN: 5 starved FEED cycles -> bubble_cnt=5; it holds through IDLE and clears to 0 on the next tile start.
